matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Sequencer that streams a whole matrix into or out of one `mn_matrix` storage instance in row-major order, optionally transposed. It issues one element access per cycle and adapts `mn_matrix`'s one-cycle registered read to a valid/ready stream. It sits between the predictor-corrector datapath (stream side) and the matrix store (memory side), so upstream units never generate element addresses themselves.

## Interface
- `DATA_W`, default 32: element width; matches `mn_matrix` data.
- `ADDR_W`, default 8: dimension and address width.
- `MAT_MAX`, default 128: largest legal dimension.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `mode` in 1: 0 = read (matrix to stream), 1 = write (stream to matrix); latched at start.
- `transpose` in 1: latched at start.
- `m_dim`, `n_dim` in `ADDR_W`: stored matrix dimensions; latched at start.
- `abort` in 1: cancels the current scan.
- `busy` out 1: high from the cycle after an accepted start until done/abort.
- `done` out 1: one-cycle pulse at the end of a scan.
- `err` out 1: one-cycle pulse with `done` on an illegal dimension.
- `mem_write`, `mem_read`, `mem_transpose` out 1: `mn_matrix` controls.
- `mem_m_addr`, `mem_n_addr` out `ADDR_W`: `mn_matrix` addresses.
- `mem_data_in` out `DATA_W`: write data.
- `mem_data_out` in `DATA_W`: `mn_matrix` read data, valid 1 cycle after `mem_read`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `DATA_W`: write stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `DATA_W`: read stream.

## Operation
- States: IDLE, RD_RUN, RD_DRAIN, WR_RUN, FINISH.
- IDLE + `start`:
  - If `m_dim` or `n_dim` is 0 or greater than `MAT_MAX`, go to FINISH with `err` set. No memory access occurs.
  - Otherwise go to RD_RUN (`mode`=0) or WR_RUN (`mode`=1).
- Logical scan size:
  - `rows`×`cols` = `m_dim`×`n_dim` when not transposed.
  - `rows`×`cols` = `n_dim`×`m_dim` when transposed.
  - Counters `r`,`c` start at 0; `c` increments first and wraps to 0 at `cols`-1, then `r` increments.
  - The last element is `r`=`rows`-1 and `c`=`cols`-1.
- Read addressing: `mem_m_addr`=`r`, `mem_n_addr`=`c`, `mem_transpose`=latched `transpose`. `mn_matrix` then returns [c][r] itself.
- Write addressing: `mem_transpose`=0.
  - Not transposed: `mem_m_addr`=`r`, `mem_n_addr`=`c`.
  - Transposed: `mem_m_addr`=`c`, `mem_n_addr`=`r`.
- RD_RUN:
  - Assert `mem_read` in a cycle only when no read is in flight, or when the output slot will be empty or draining (`!out_valid` or `out_ready`) in the cycle the data lands.
  - Returned data loads `out_data` and sets `out_valid`.
  - After the last read issues, go to RD_DRAIN.
- RD_DRAIN: wait until the final element has been accepted (`out_valid`&&`out_ready`), then go to FINISH.
- WR_RUN:
  - `in_ready`=1.
  - Each `in_valid`&&`in_ready` cycle drives `mem_write`=1 with `mem_data_in`=`in_data` in the same cycle (combinational pass-through) and advances the counters.
  - The last write goes to FINISH.
- FINISH: `done`=1 (plus `err` if flagged) for one cycle, then IDLE.
- `abort`:
  - In any non-IDLE state, go to IDLE next cycle.
  - Clear `out_valid`, discard any in-flight read, no `done`.
  - `abort` has priority over `start` and over stream transfers in the same cycle.
- `start` while busy is ignored.
- `mem_read` and `mem_write` are never asserted together. Neither is asserted in IDLE or FINISH.

## Timing
- Reset (`reset`=0 at a clock edge) forces all of the following to 0 in the next cycle:
  - state IDLE, counters, `busy`, `done`, `err`
  - `mem_read`, `mem_write`, `mem_transpose`, `mem_*_addr`
  - `out_valid`, `out_data`, `in_ready`
- Reset mid-scan behaves like `abort` (memory contents are untouched).
- Read latency: `start` at cycle 0, first `mem_read` at cycle 1, first `out_valid` at cycle 2.
- Read throughput is 1 element/cycle while `out_ready`=1.
- For an R×C read with `out_ready` held high, `done` pulses at cycle R·C+3.
- Write: one element per accepted beat, zero added latency. `done` pulses the cycle after the last beat.
- `out_data` is held stable while `out_valid`&&`!out_ready`.

## Structure
- Shared package `matrix_pkg` holds:
  - `DATA_W`, `ADDR_W`, `MAT_MAX`
  - the state enum `scan_state_t` (IDLE, RD_RUN, RD_DRAIN, WR_RUN, FINISH)
- One sub-module, `mat_addr_gen`, holds the row/col counters.
  - Inputs: `clear`, `advance`, `rows`, `cols`, `swap`.
  - Outputs: `m_addr`, `n_addr`, `last`.
- The FSM and the output holding register stay in `matrix_scan_ctrl`.

## Test plan
- Write 2×3, no transpose, data 1..6 with `in_valid` held high → writes at (0,0)…(1,2) in order; `done` pulses on cycle 7. A subsequent 2×3 read returns 1,2,3,4,5,6.
- Same matrix, transposed read (3×2 stream) with `out_ready`=1 → outputs 1,4,2,5,3,6; `done` pulses at cycle 9.
- Transposed 3×2 read with `out_ready` toggling 1,0,0,1,… → no element dropped or duplicated; `out_data` stable while stalled; `mem_read` never issued with a full, non-draining slot.
- `start` with `m_dim`=0, then with `n_dim`=200 → `done` and `err` pulse on cycle 1 each time; zero `mem_read`/`mem_write` cycles.
- `abort` on the 3rd element of a 4×4 read, then a new `start` → `busy` drops next cycle; no `done`; `out_valid`=0; the second scan restarts at (0,0).
- `reset`=0 mid-write → all outputs are 0 next cycle; elements already written remain; a new scan restarts at (0,0).

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the matrix scan sequencer.
package matrix_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int MAT_MAX = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_RUN   = 3'd1,
    RD_DRAIN = 3'd2,
    WR_RUN   = 3'd3,
    FINISH   = 3'd4
  } scan_state_t;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Memory-side and stream-side signal bundle of the matrix scan sequencer.
// master = sequencer, slave = environment (matrix store plus stream peers).
interface matrix_scan_ctrl_if #(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int ADDR_W = matrix_pkg::ADDR_W
);

  logic              mem_write;
  logic              mem_read;
  logic              mem_transpose;
  logic [ADDR_W-1:0] mem_m_addr;
  logic [ADDR_W-1:0] mem_n_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mem_write, mem_read, mem_transpose, mem_m_addr, mem_n_addr, mem_data_in,
    output in_ready, out_valid, out_data,
    input  mem_data_out, in_valid, in_data, out_ready
  );

  modport slave (
    input  mem_write, mem_read, mem_transpose, mem_m_addr, mem_n_addr, mem_data_in,
    input  in_ready, out_valid, out_data,
    output mem_data_out, in_valid, in_data, out_ready
  );

endinterface

// File: rtl/mat_addr_gen.sv
// Row-major row/column counter pair; swap exchanges the roles of the
// counters on the address outputs (used for transposed writes).
module mat_addr_gen #(
  parameter int ADDR_W = matrix_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] rows,
  input  logic [ADDR_W-1:0] cols,
  input  logic              swap,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] n_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_r;
  logic [ADDR_W-1:0] c_r;
  logic              row_end_s;
  logic              col_end_s;

  // End-of-row / end-of-matrix detection and address routing.
  always_comb begin
    row_end_s = (r_r == (rows - ADDR_ONE));
    col_end_s = (c_r == (cols - ADDR_ONE));
    last      = row_end_s && col_end_s;
    if (swap) begin
      m_addr = c_r;
      n_addr = r_r;
    end else begin
      m_addr = r_r;
      n_addr = c_r;
    end
  end

  // Column counter steps first; row steps when the column wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_r <= '0;
      c_r <= '0;
    end else if (clear) begin
      r_r <= '0;
      c_r <= '0;
    end else if (advance) begin
      if (col_end_s) begin
        c_r <= '0;
        if (row_end_s) begin
          r_r <= '0;
        end else begin
          r_r <= r_r + ADDR_ONE;
        end
      end else begin
        c_r <= c_r + ADDR_ONE;
      end
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Streams a whole matrix into or out of the matrix store in row-major order,
// optionally transposed, adapting the store's registered read to valid/ready.
module matrix_scan_ctrl #(
  parameter int DATA_W  = matrix_pkg::DATA_W,
  parameter int ADDR_W  = matrix_pkg::ADDR_W,
  parameter int MAT_MAX = matrix_pkg::MAT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              transpose,
  input  logic [ADDR_W-1:0] m_dim,
  input  logic [ADDR_W-1:0] n_dim,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  matrix_scan_ctrl_if.master bus
);

  import matrix_pkg::scan_state_t;
  import matrix_pkg::IDLE;
  import matrix_pkg::RD_RUN;
  import matrix_pkg::RD_DRAIN;
  import matrix_pkg::WR_RUN;
  import matrix_pkg::FINISH;

  localparam logic [ADDR_W:0] MAX_DIM = MAT_MAX[ADDR_W:0];

  scan_state_t       state_r;
  scan_state_t       state_nxt_s;
  logic [ADDR_W-1:0] rows_r;
  logic [ADDR_W-1:0] cols_r;
  logic              trans_r;
  logic              err_r;
  // hold_r: the store's read register carries an element not yet moved into
  // the output slot. The store keeps that value until the next mem_read.
  logic              hold_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;

  logic              start_ok_s;
  logic              dim_bad_s;
  logic              move_s;
  logic              out_fire_s;
  logic              rd_issue_s;
  logic              wr_fire_s;
  logic              clear_s;
  logic              swap_s;
  logic              last_s;
  logic [ADDR_W-1:0] m_addr_s;
  logic [ADDR_W-1:0] n_addr_s;

  // Handshake and issue decode; abort overrides every transfer.
  always_comb begin
    start_ok_s = (state_r == IDLE) && start && !abort;
    dim_bad_s  = (m_dim == '0) || (n_dim == '0) ||
                 ({1'b0, m_dim} > MAX_DIM) || ({1'b0, n_dim} > MAX_DIM);
    move_s     = hold_r && (!out_valid_r || bus.out_ready);
    out_fire_s = out_valid_r && bus.out_ready;
    // A new read only issues when the slot is free or draining, so the
    // element it returns never overwrites one still waiting in the store.
    rd_issue_s = (state_r == RD_RUN) && !abort && (!out_valid_r || bus.out_ready);
    wr_fire_s  = (state_r == WR_RUN) && !abort && bus.in_valid;
    clear_s    = (state_r == IDLE) || (state_r == FINISH) || abort;
    swap_s     = trans_r && (state_r == WR_RUN);
  end

  mat_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .advance (rd_issue_s || wr_fire_s),
    .rows    (rows_r),
    .cols    (cols_r),
    .swap    (swap_s),
    .m_addr  (m_addr_s),
    .n_addr  (n_addr_s),
    .last    (last_s)
  );

  // Next-state logic of the scan FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (dim_bad_s) begin
            state_nxt_s = FINISH;
          end else if (mode) begin
            state_nxt_s = WR_RUN;
          end else begin
            state_nxt_s = RD_RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_RUN: begin
        if (rd_issue_s && last_s) begin
          state_nxt_s = RD_DRAIN;
        end else begin
          state_nxt_s = RD_RUN;
        end
      end
      RD_DRAIN: begin
        if (!hold_r && out_fire_s) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = RD_DRAIN;
        end
      end
      WR_RUN: begin
        if (wr_fire_s && last_s) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = WR_RUN;
        end
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan geometry latched at an accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_r  <= '0;
      cols_r  <= '0;
      trans_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (start_ok_s) begin
      rows_r  <= transpose ? n_dim : m_dim;
      cols_r  <= transpose ? m_dim : n_dim;
      trans_r <= transpose;
      err_r   <= dim_bad_s;
    end
  end

  // Read-return tracking and the output holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (abort) begin
      hold_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (rd_issue_s) begin
        hold_r <= 1'b1;
      end else if (move_s) begin
        hold_r <= 1'b0;
      end
      if (move_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.mem_data_out;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Output decode from state and holding registers.
  always_comb begin
    busy              = (state_r != IDLE);
    done              = (state_r == FINISH) && !abort;
    err               = done && err_r;
    bus.mem_read      = rd_issue_s;
    bus.mem_write     = wr_fire_s;
    bus.mem_transpose = (state_r == RD_RUN) && trans_r;
    bus.mem_m_addr    = m_addr_s;
    bus.mem_n_addr    = n_addr_s;
    bus.mem_data_in   = wr_fire_s ? bus.in_data : '0;
    bus.in_ready      = (state_r == WR_RUN) && !abort;
    bus.out_valid     = out_valid_r;
    bus.out_data      = out_data_r;
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench: behavioural matrix store, golden matrix, and a
// per-cycle monitor deriving every expected address/element from the scan index.
module tb_matrix_scan_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, start = 1'b0, mode = 1'b0, transpose = 1'b0, abort = 1'b0;
  logic [AW-1:0] m_dim = '0, n_dim = '0;
  logic          busy, done, err;

  matrix_scan_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  matrix_scan_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAT_MAX(128)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .transpose(transpose),
    .m_dim(m_dim), .n_dim(n_dim), .abort(abort), .busy(busy), .done(done),
    .err(err), .bus(bus)
  );

  // Behavioural matrix store: registered read that holds until the next read.
  logic [DW-1:0] mem [0:255][0:255];
  logic [DW-1:0] rd_q = '0;
  assign bus.mem_data_out = rd_q;
  always @(posedge clk) begin
    if (bus.mem_read)
      rd_q <= bus.mem_transpose ? mem[bus.mem_n_addr][bus.mem_m_addr]
                                : mem[bus.mem_m_addr][bus.mem_n_addr];
    if (bus.mem_write) mem[bus.mem_m_addr][bus.mem_n_addr] <= bus.mem_data_in;
  end

  int total = 0, bad = 0;
  int s_rows = 1, s_cols = 1;
  bit s_trans = 1'b0, mon_en = 1'b0;
  int wk = 0, rk = 0, rdi = 0, nacc = 0;
  logic [DW-1:0] wdata [$];
  logic [DW-1:0] got [$];
  logic [DW-1:0] gold [0:255][0:255];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int lit_row [6] = '{1, 2, 3, 4, 5, 6};
  int lit_tr  [6] = '{1, 4, 2, 5, 3, 6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: every access and transfer checked against the scan index.
  always @(negedge clk) begin
    int r, c, em, en;
    if (mon_en) begin
      chk("rw_excl", bus.mem_read & bus.mem_write, 0);
      if (bus.mem_read | bus.mem_write) nacc++;
      if (bus.mem_write) begin
        r = wk / s_cols; c = wk % s_cols;
        em = s_trans ? c : r; en = s_trans ? r : c;
        chk("wr_idx", wk < s_rows * s_cols, 1);
        chk("wr_m_addr", bus.mem_m_addr, em);
        chk("wr_n_addr", bus.mem_n_addr, en);
        chk("wr_tr", bus.mem_transpose, 0);
        chk("wr_data", bus.mem_data_in, bus.in_data);
        chk("wr_beat", bus.in_valid & bus.in_ready, 1);
        gold[em][en] = bus.in_data;
        wk++;
      end
      if (bus.mem_read) begin
        chk("rd_slot", bus.out_valid & ~bus.out_ready, 0);
        chk("rd_idx", rdi < s_rows * s_cols, 1);
        chk("rd_m_addr", bus.mem_m_addr, rdi / s_cols);
        chk("rd_n_addr", bus.mem_n_addr, rdi % s_cols);
        chk("rd_tr", bus.mem_transpose, s_trans);
        rdi++;
      end
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready && !abort) begin
        r = rk / s_cols; c = rk % s_cols;
        chk("out_idx", rk < s_rows * s_cols, 1);
        chk("out_data", bus.out_data, s_trans ? gold[c][r] : gold[r][c]);
        got.push_back(bus.out_data);
        rk++;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !abort;
      prev_data  = bus.out_data;
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd"}, bus.mem_read, 0);
    chk({tag, "_wr"}, bus.mem_write, 0);
    chk({tag, "_tr"}, bus.mem_transpose, 0);
    chk({tag, "_maddr"}, bus.mem_m_addr, 0);
    chk({tag, "_naddr"}, bus.mem_n_addr, 0);
    chk({tag, "_ovalid"}, bus.out_valid, 0);
    chk({tag, "_iready"}, bus.in_ready, 0);
  endtask

  // One scan: rdy_mode 0=high 1=1,0,0 pattern 2=random; vld_mode 0=high 1=random.
  task automatic run_scan(input bit md, input bit tr, input int m, input int n,
                          input int rdy_mode, input int vld_mode,
                          input int abort_el, input int reset_el,
                          output int dcyc, output bit derr);
    int cyc;
    bit fin;
    s_trans = tr;
    s_rows = tr ? n : m;
    s_cols = tr ? m : n;
    if (s_cols < 1) s_cols = 1;
    wk = 0; rk = 0; rdi = 0;
    got.delete();
    dcyc = -1; derr = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; transpose = tr;
    m_dim = m[AW-1:0]; n_dim = n[AW-1:0];
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; abort = 1'b0; reset = 1'b1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_data  = (wk < wdata.size()) ? wdata[wk] : $urandom;
      if (abort_el >= 0 && rk == abort_el && bus.out_valid) abort = 1'b1;
      if (reset_el >= 0 && wk == reset_el) begin
        reset = 1'b0;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (abort || !reset) begin
        chk("cut_done", done, 0);
        @(posedge clk); #1;
        abort = 1'b0; reset = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        check_quiet("cut");
        chk("cut_odata", reset_el >= 0 ? bus.out_data : 0, 0);
        fin = 1'b1;
      end else if (done) begin
        dcyc = cyc;
        derr = err;
        chk("fin_acc", bus.mem_read | bus.mem_write, 0);
        fin = 1'b1;
      end else begin
        chk("run_busy", busy, 1);
        chk("run_err", err, 0);
        if (cyc > 3000) begin
          chk("timeout", cyc, 0);
          fin = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
  endtask

  initial begin
    int d, n0, rr, cc;
    bit e, md, tr;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_quiet("rst");
    chk("rst_odata", bus.out_data, 0);
    mon_en = 1'b1;

    // 2x3 write of 1..6, then straight and transposed reads.
    wdata.delete();
    for (int i = 1; i <= 6; i++) wdata.push_back(DW'(i));
    run_scan(1'b1, 1'b0, 2, 3, 0, 0, -1, -1, d, e);
    chk("w23_done_cyc", d, 7); chk("w23_err", e, 0); chk("w23_beats", wk, 6);
    run_scan(1'b0, 1'b0, 2, 3, 0, 0, -1, -1, d, e);
    chk("r23_done_cyc", d, 9); chk("r23_len", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("r23_lit", got.size() > i ? got[i] : '1, lit_row[i]);
    run_scan(1'b0, 1'b1, 2, 3, 0, 0, -1, -1, d, e);
    chk("r32t_done_cyc", d, 9); chk("r32t_len", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("r32t_lit", got.size() > i ? got[i] : '1, lit_tr[i]);
    run_scan(1'b0, 1'b1, 2, 3, 1, 0, -1, -1, d, e);
    chk("r32s_len", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("r32s_lit", got.size() > i ? got[i] : '1, lit_tr[i]);

    // Illegal dimensions: immediate done+err, no memory traffic.
    n0 = nacc;
    run_scan(1'b0, 1'b0, 0, 3, 0, 0, -1, -1, d, e);
    chk("bad_m_cyc", d, 1); chk("bad_m_err", e, 1);
    run_scan(1'b1, 1'b0, 2, 200, 0, 0, -1, -1, d, e);
    chk("bad_n_cyc", d, 1); chk("bad_n_err", e, 1);
    chk("bad_noacc", nacc, n0);

    // Full 4x4 write, aborted read, then a complete read from (0,0).
    wdata.delete();
    for (int i = 0; i < 16; i++) wdata.push_back($urandom);
    run_scan(1'b1, 1'b0, 4, 4, 0, 0, -1, -1, d, e);
    chk("w44_done_cyc", d, 17);
    run_scan(1'b0, 1'b0, 4, 4, 0, 0, 2, -1, d, e);
    chk("abort_nodone", d, -1); chk("abort_seen", rk, 2);
    run_scan(1'b0, 1'b0, 4, 4, 2, 0, -1, -1, d, e);
    chk("r44_len", rk, 16);

    // Reset in the middle of a write, restart, then read back everything.
    wdata.delete();
    for (int i = 0; i < 16; i++) wdata.push_back($urandom);
    run_scan(1'b1, 1'b0, 4, 4, 0, 0, -1, 5, d, e);
    chk("rstw_nodone", d, -1); chk("rstw_beats", wk, 5);
    wdata.delete();
    for (int i = 0; i < 4; i++) wdata.push_back($urandom);
    run_scan(1'b1, 1'b0, 2, 2, 0, 0, -1, -1, d, e);
    chk("w22_done_cyc", d, 5);
    run_scan(1'b0, 1'b0, 4, 4, 2, 0, -1, -1, d, e);
    chk("rb44_len", rk, 16);

    // Randomized scans within the populated 4x4 region.
    for (int k = 0; k < 10; k++) begin
      md = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      rr = $urandom_range(1, 4);
      cc = $urandom_range(1, 4);
      wdata.delete();
      for (int i = 0; i < rr * cc; i++) wdata.push_back($urandom);
      run_scan(md, tr, rr, cc, 2, 1, -1, -1, d, e);
      chk("rnd_err", e, 0);
      chk("rnd_count", md ? wk : rk, rr * cc);
      if (md == 1'b0 && tr == 1'b0) chk("rnd_min_lat", d >= rr * cc + 3, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
